io_port_ctrl: RTL and testbench

- Memory-mapped controller for the 8-bit IO port.
- Sequences CPU read and write accesses to the port through a req/ack handshake.
- Holds the port configuration: output data, direction, and edge-interrupt setup.
- Synchronizes the raw input pins and raises a level interrupt to the core; sits on the data bus beside the RAM decoder.

---
 rtl/io_pkg.sv | 11 +
 rtl/io_sync_edge.sv | 34 +++
 rtl/io_port_ctrl.sv | 86 ++++++++
 tb/tb_io_port_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: register offsets, FSM state type and default pin count for the IO port controller
package io_pkg;
  localparam int IO_WIDTH = 8;
  localparam logic [4:0] OFF_IN = 5'd0;
  localparam logic [4:0] OFF_OUT = 5'd4;
  localparam logic [4:0] OFF_DIR = 5'd8;
  localparam logic [4:0] OFF_IE = 5'd12;
  localparam logic [4:0] OFF_IS = 5'd16;
  localparam logic [4:0] OFF_EDGE = 5'd20;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_DROP} io_state_t;
endpackage

// File: rtl/io_sync_edge.sv
// io_sync_edge: io_in -> SYNC_STAGES flop synchronizer -> synced; edge_sel (1 rise / 0 fall) -> edge_hit, masked for SYNC_STAGES cycles after reset
module io_sync_edge #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] edge_sel,
  output logic [WIDTH-1:0] synced,
  output logic [WIDTH-1:0] edge_hit
);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rise, fall;
  always_comb begin
    s_d = {s_q[SYNC_STAGES-2:0], io_in};
    cnt_d = (cnt_q == CW'(SYNC_STAGES)) ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
      cnt_q <= '0;
    end else begin
      s_q <= s_d;
      cnt_q <= cnt_d;
    end
  end
  assign synced = s_q[SYNC_STAGES-1];
  assign rise = s_q[SYNC_STAGES-2] & ~s_q[SYNC_STAGES-1];
  assign fall = ~s_q[SYNC_STAGES-2] & s_q[SYNC_STAGES-1];
  assign edge_hit = (cnt_q == CW'(SYNC_STAGES)) ? ((edge_sel & rise) | (~edge_sel & fall)) : '0;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: bus-mapped IO port (req/we/adress/wdata -> ack/rdata/io_control; io_in -> io_out/io_oe/irq)
module io_port_ctrl
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd4,
  parameter int WIDTH = IO_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      adress,
  input  logic [31:0]      wdata,
  output logic             ack,
  output logic [31:0]      rdata,
  output logic             io_control,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  output logic             irq
);
  io_state_t state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, ie_q, ie_d, is_q, is_d, edge_q, edge_d;
  logic [WIDTH-1:0] wdata_q, wdata_d, synced, edge_hit, rval;
  logic [4:0] off_q, off_d;
  logic we_q, we_d, ack_q, ack_d, ioc_q, ioc_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, off;
  logic hit, start, wr, unused_wdata;
  io_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .io_in(io_in), .edge_sel(edge_q), .synced(synced), .edge_hit(edge_hit)
  );
  assign unused_wdata = ^wdata[31:WIDTH];
  always_comb begin
    off = adress - BASE_ADDR;
    hit = (off <= 32'd20) && (adress[1:0] == 2'b00);
    start = (state_q == IDLE) && req && hit;
    wr = (state_q == ACCESS) && we_q;
    rval = (off[4:0] == OFF_IN) ? synced :
           (off[4:0] == OFF_OUT) ? out_q :
           (off[4:0] == OFF_DIR) ? dir_q :
           (off[4:0] == OFF_IE) ? ie_q :
           (off[4:0] == OFF_IS) ? is_q :
           (off[4:0] == OFF_EDGE) ? edge_q : '0;
    state_d = (state_q == IDLE) ? (start ? ACCESS : IDLE) : (req ? WAIT_DROP : IDLE);
    ack_d = start;
    ioc_d = start && !we;
    rdata_d = (start && !we) ? 32'(rval) : '0;
    off_d = start ? off[4:0] : off_q;
    we_d = start ? we : we_q;
    wdata_d = start ? wdata[WIDTH-1:0] : wdata_q;
    out_d = (wr && off_q == OFF_OUT) ? wdata_q : out_q;
    dir_d = (wr && off_q == OFF_DIR) ? wdata_q : dir_q;
    ie_d = (wr && off_q == OFF_IE) ? wdata_q : ie_q;
    edge_d = (wr && off_q == OFF_EDGE) ? wdata_q : edge_q;
    is_d = (is_q & ~((wr && off_q == OFF_IS) ? wdata_q : '0)) | edge_hit;
    irq_d = |(is_q & ie_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {out_q, dir_q, ie_q, is_q, edge_q, wdata_q} <= '0;
      {off_q, we_q, ack_q, ioc_q, irq_q, rdata_q} <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      dir_q <= dir_d;
      ie_q <= ie_d;
      is_q <= is_d;
      edge_q <= edge_d;
      wdata_q <= wdata_d;
      off_q <= off_d;
      we_q <= we_d;
      ack_q <= ack_d;
      ioc_q <= ioc_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  end
  assign ack = ack_q;
  assign io_control = ioc_q;
  assign rdata = rdata_q;
  assign io_out = out_q;
  assign io_oe = dir_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed table, corner sequences and randomized model check of io_port_ctrl
module tb_io_port_ctrl;
  localparam int N = 2;
  logic clk = 0, rst_n, req, we, ack, io_control, irq;
  logic [31:0] adress, wdata, rdata;
  logic [7:0] io_in, io_out, io_oe;
  int tests = 0, fails = 0;

  io_port_ctrl #(.BASE_ADDR(32'd4), .WIDTH(8), .SYNC_STAGES(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adress(adress), .wdata(wdata),
    .ack(ack), .rdata(rdata), .io_control(io_control),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] data;
    logic hit;
    logic [31:0] rd;
    logic [7:0] out;
    logic [7:0] oe;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] m_out, m_dir, m_ie, m_is, m_edge, m_pin, np;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // one bus access: request, check the response cycle, drop req, let the write land
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic exp_hit, input logic [31:0] exp_rd, input string n);
    req = 1;
    we = w;
    adress = a;
    wdata = d;
    cyc();
    chk({n, " ack"}, 32'(ack), 32'(exp_hit));
    chk({n, " io_control"}, 32'(io_control), 32'(exp_hit && !w));
    chk({n, " rdata"}, rdata, (exp_hit && !w) ? exp_rd : 32'h0);
    req = 0;
    cyc();
  endtask

  function automatic logic [7:0] model_rd(input int idx);
    case (idx)
      0: return m_pin;
      1: return m_out;
      2: return m_dir;
      3: return m_ie;
      4: return m_is;
      default: return m_edge;
    endcase
  endfunction

  initial begin
    tbl[0]  = '{0, 32'd4,  32'h0,        1, 32'hA5, 8'h00, 8'h00};
    tbl[1]  = '{1, 32'd8,  32'h12345678, 1, 32'h0,  8'h78, 8'h00};
    tbl[2]  = '{1, 32'd12, 32'hFF,       1, 32'h0,  8'h78, 8'hFF};
    tbl[3]  = '{0, 32'd8,  32'h0,        1, 32'h78, 8'h78, 8'hFF};
    tbl[4]  = '{0, 32'd12, 32'h0,        1, 32'hFF, 8'h78, 8'hFF};
    tbl[5]  = '{0, 32'd0,  32'h0,        0, 32'h0,  8'h78, 8'hFF};
    tbl[6]  = '{0, 32'd6,  32'h0,        0, 32'h0,  8'h78, 8'hFF};
    tbl[7]  = '{0, 32'd28, 32'h0,        0, 32'h0,  8'h78, 8'hFF};
    tbl[8]  = '{1, 32'd28, 32'h00,       0, 32'h0,  8'h78, 8'hFF};
    tbl[9]  = '{1, 32'd10, 32'h00,       0, 32'h0,  8'h78, 8'hFF};
    tbl[10] = '{1, 32'd4,  32'h00,       1, 32'h0,  8'h78, 8'hFF};
    tbl[11] = '{0, 32'd4,  32'h0,        1, 32'hA5, 8'h78, 8'hFF};
    tbl[12] = '{1, 32'd24, 32'h01,       1, 32'h0,  8'h78, 8'hFF};
    tbl[13] = '{0, 32'd20, 32'h0,        1, 32'h00, 8'h78, 8'hFF};

    rst_n = 0; req = 0; we = 0; adress = 0; wdata = 0; io_in = 8'hA5;
    repeat (3) cyc();
    rst_n = 1;
    chk("reset ack", 32'(ack), 0);
    chk("reset io_control", 32'(io_control), 0);
    chk("reset rdata", rdata, 0);
    chk("reset io_out", 32'(io_out), 0);
    chk("reset io_oe", 32'(io_oe), 0);
    chk("reset irq", 32'(irq), 0);
    repeat (4) cyc();

    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].hit, tbl[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d io_out", i), 32'(io_out), 32'(tbl[i].out));
      chk($sformatf("vec%0d io_oe", i), 32'(io_oe), 32'(tbl[i].oe));
    end

    req = 1; we = 0; adress = 32'd8;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("held req cyc%0d ack", k), 32'(ack), 32'(k == 1));
    end
    req = 0;
    cyc();
    chk("held req drop ack", 32'(ack), 0);
    req = 1;
    cyc();
    chk("held req re-raise ack", 32'(ack), 1);
    req = 0;
    cyc();

    bus(1, 32'd16, 32'h01, 1, 0, "wr IE");
    io_in = 8'h00;
    repeat (5) cyc();
    bus(1, 32'd20, 32'hFF, 1, 0, "clr IS");
    cyc();
    chk("irq idle", 32'(irq), 0);
    io_in = 8'h01;
    for (int k = 0; k < N + 2 && !irq; k++) cyc();
    chk("irq on rise", 32'(irq), 1);
    bus(0, 32'd20, 0, 1, 32'h01, "rd IS after rise");
    bus(1, 32'd20, 32'h01, 1, 0, "w1c IS");
    cyc();
    chk("irq after w1c", 32'(irq), 0);
    io_in = 8'h00;
    repeat (5) cyc();
    io_in = 8'h01;
    bus(1, 32'd20, 32'h01, 1, 0, "w1c with rise");
    bus(0, 32'd20, 0, 1, 32'h01, "rd IS set wins");
    chk("irq set wins", 32'(irq), 1);

    io_in = 8'h00;
    req = 1; we = 1; adress = 32'd8; wdata = 32'hAB;
    cyc();
    chk("mid rst access ack", 32'(ack), 1);
    rst_n = 0;
    req = 0;
    cyc();
    chk("mid rst ack", 32'(ack), 0);
    chk("mid rst io_out", 32'(io_out), 0);
    chk("mid rst io_oe", 32'(io_oe), 0);
    chk("mid rst irq", 32'(irq), 0);
    rst_n = 1;
    repeat (3) cyc();
    bus(0, 32'd8, 0, 1, 32'h0, "rd OUT after rst");
    bus(0, 32'd20, 0, 1, 32'h0, "rd IS after rst");

    m_out = 0; m_dir = 0; m_ie = 0; m_is = 0; m_edge = 0; m_pin = 0;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        np = 8'($urandom);
        m_is = m_is | ((m_pin ^ np) & ~(np ^ m_edge));
        m_pin = np;
        io_in = np;
        repeat (N + 3) cyc();
      end else begin
        int idx, mi;
        logic w, h;
        logic [31:0] a, d;
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        h = $urandom_range(0, 4) != 0;
        idx = $urandom_range(0, 5);
        mi = $urandom_range(0, 3);
        a = h ? 32'(4 + 4 * idx) : (mi == 0 ? 32'd0 : mi == 1 ? 32'd6 : mi == 2 ? 32'd28 : 32'hFFFF_FFFC);
        bus(w, a, d, h, 32'(model_rd(idx)), $sformatf("rnd%0d", it));
        if (h && w) begin
          case (idx)
            1: m_out = d[7:0];
            2: m_dir = d[7:0];
            3: m_ie = d[7:0];
            4: m_is = m_is & ~d[7:0];
            5: m_edge = d[7:0];
            default: ;
          endcase
        end
        cyc();
      end
      chk($sformatf("rnd%0d io_out", it), 32'(io_out), 32'(m_out));
      chk($sformatf("rnd%0d io_oe", it), 32'(io_oe), 32'(m_dir));
      chk($sformatf("rnd%0d irq", it), 32'(irq), 32'(|(m_is & m_ie)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
